// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared FSM state, AXI response codes and protection default for the register arbiter
package axil_arb_pkg;

    typedef enum logic [2:0] {IDLE, WR, B, AR, R, RESP} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_reg_arbiter_rr_arbiter.sv
// rr_arbiter: combinational N-way round-robin pick, first request at or above ptr with wrap-around
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_id,
    output logic          gnt_vld
);

    // scan downward so the candidate closest to ptr is the last (winning) assignment
    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_id  = PW'((int'(ptr) + k) % N);
                gnt_vld = 1'b1;
            end
        end
        gnt = gnt_vld ? (N'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter: round-robin share of one AXI4-Lite master among N_REQ requesters; AXIL_ARB_STATS_EN adds stat_cnt
module axil_reg_arbiter
    import axil_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    ack,
    output logic [DW-1:0]       rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [AW-1:0]       m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DW-1:0]       m_axi_wdata,
    output logic [DW/8-1:0]     m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [AW-1:0]       m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DW-1:0]       m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
`ifdef AXIL_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0] stat_cnt
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] sel_q, sel_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_id;
    logic             gnt_vld;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_vld(gnt_vld)
    );

    // transaction FSM: capture in IDLE, run one AXI write or read, pulse ack for one cycle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: if (gnt_vld) begin
                sel_d     = gnt;
                addr_d    = req_addr[int'(gnt_id)*AW +: AW];
                wdata_d   = req_wdata[int'(gnt_id)*DW +: DW];
                ptr_d     = (gnt_id == PW'(N_REQ - 1)) ? '0 : gnt_id + PW'(1);
                rdata_d   = '0;
                resp_d    = RESP_OKAY;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_we[gnt_id] ? WR : AR;
            end
            WR: begin
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                state_d   = (aw_done_d && w_done_d) ? B : WR;
            end
            B: if (m_axi_bvalid) begin
                resp_d  = m_axi_bresp;
                state_d = RESP;
            end
            AR: state_d = m_axi_arready ? R : AR;
            R: if (m_axi_rvalid) begin
                rdata_d = m_axi_rdata;
                resp_d  = m_axi_rresp;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and captured-request registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign ack           = (state_q == RESP) ? sel_q : '0;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_wstrb   = '1;
    assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
    assign m_axi_bready  = (state_q == B);
    assign m_axi_arvalid = (state_q == AR);
    assign m_axi_rready  = (state_q == R);

`ifdef AXIL_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

    // per-requester completion counters, saturating at 0xFFFF
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            cnt_d[i] = (state_q == RESP && sel_q[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
    end

    // counter registers
    always_ff @(posedge ACLK) begin
        if (ARESET) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb_axil_reg_arbiter: directed bench with an AXI-Lite slave, a round-robin/memory reference model and per-cycle checks
module tb_axil_reg_arbiter;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0, req_we = '0;
    logic [127:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  ack;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int errors = 0, checks = 0, cyc = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] r_err = 2'b00;

    axil_reg_arbiter dut (
        .ACLK(clk), .ARESET(rst),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AXI-Lite slave with programmable stalls ----------------
    logic [31:0] smem [16];
    int aw_wait = 0, w_wait = 0, b_cnt = 0;
    logic got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign arready = arvalid;
    assign bvalid  = b_pend && (b_cnt >= b_dly);
    assign bresp   = 2'b00;
    assign rvalid  = r_pend;
    assign rdata   = smem[s_araddr[5:2]];
    assign rresp   = r_err;

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; b_cnt <= 0;
            got_aw <= 0; got_w <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            if (awvalid && !awready) aw_wait <= aw_wait + 1;
            if (awvalid && awready) begin got_aw <= 1; aw_wait <= 0; s_awaddr <= awaddr; end
            if (wvalid && !wready) w_wait <= w_wait + 1;
            if (wvalid && wready) begin got_w <= 1; w_wait <= 0; s_wdata <= wdata; end
            if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready)) && !b_pend) begin
                b_pend <= 1; b_cnt <= 0; got_aw <= 0; got_w <= 0;
                smem[(awvalid && awready) ? awaddr[5:2] : s_awaddr[5:2]] <= (wvalid && wready) ? wdata : s_wdata;
            end
            if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
            if (bvalid && bready) b_pend <= 0;
            if (arvalid && arready) begin r_pend <= 1; s_araddr <= araddr; end
            if (rvalid && rready) r_pend <= 0;
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] mmem [16];
    logic [3:0]  mpend = '0;
    int          mptr = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;

    function automatic int rr_pick(input logic [3:0] p, input int ptr);
        for (int k = 0; k < 4; k++)
            if (p[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    always @(negedge clk) begin
        int id;
        logic [3:0] idx;
        if (rst) begin
            mpend = '0; mptr = 0;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
        end else begin
            check("awprot", awprot, 3'b000);
            check("arprot", arprot, 3'b000);
            check("wstrb", wstrb, 4'hF);
            if (p_awv && !p_awr) begin check("awvalid_hold", awvalid, 1'b1); check("awaddr_hold", awaddr, p_awaddr); end
            if (p_wv && !p_wr) begin check("wvalid_hold", wvalid, 1'b1); check("wdata_hold", wdata, p_wdata); end
            if (p_arv && !p_arr) begin check("arvalid_hold", arvalid, 1'b1); check("araddr_hold", araddr, p_araddr); end
            if (ack != 0) begin
                id = rr_pick(mpend, mptr);
                if (id < 0) check("ack_unexpected", ack, 4'h0);
                else begin
                    check("ack_id", ack, 64'(1) << id);
                    idx = req_addr[id*32+2 +: 4];
                    if (req_we[id]) begin
                        check("wr_rdata", rsp_rdata, 32'h0);
                        check("wr_resp", rsp_resp, 2'b00);
                        mmem[idx] = req_wdata[id*32 +: 32];
                    end else begin
                        check("rd_rdata", rsp_rdata, mmem[idx]);
                        check("rd_resp", rsp_resp, r_err);
                    end
                    mpend[id] = 1'b0;
                    mptr = (id + 1) % 4;
                end
            end
            mpend |= req;
            {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = {awvalid, awready, wvalid, wready, arvalid, arready};
            p_awaddr = awaddr; p_wdata = wdata; p_araddr = araddr;
        end
    end

    // ---------------- directed stimulus ----------------
    int          order [4];
    logic [31:0] got_rd [4];
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;

    task automatic set_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[i] = we;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    task automatic run(input logic [3:0] mask, input int lat0, input int step);
        int t0, n;
        @(posedge clk); #1;
        req = mask; t0 = cyc; n = 0;
        for (int c = 0; c < 100 && req != 0; c++) begin
            @(posedge clk); #1;
            if (ack != 0) begin
                check("ack_latency", cyc - t0, lat0 + n * step);
                for (int i = 0; i < 4; i++)
                    if (ack[i]) begin order[n] = i; got_rd[i] = rsp_rdata; end
                last_rdata = rsp_rdata; last_resp = rsp_resp;
                n++;
                req &= ~ack;
            end
        end
        if (req != 0) begin check("ack_timeout", req, 4'h0); req = '0; end
        @(posedge clk); #1;
        check("ack_single_pulse", ack, 4'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, ack, 4'h0);
        check({tag, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check({tag, "_addr"}, {awaddr, araddr, wdata}, 96'h0);
        check({tag, "_rsp"}, {rsp_rdata, rsp_resp}, 34'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin smem[i] = '0; mmem[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        set_req(0, 1'b1, BASE, 32'h0101FFFF);
        run(4'b0001, 3, 0);
        check("single_write_resp", last_resp, 2'b00);

        set_req(0, 1'b0, BASE, 32'h0);
        run(4'b0001, 3, 0);
        check("readback0", last_rdata, 32'h0101FFFF);

        set_req(3, 1'b0, BASE, 32'h0);
        run(4'b1000, 3, 0);
        check("readback_by3", last_rdata, 32'h0101FFFF);

        set_req(0, 1'b1, BASE + 0, 32'h0101FFFF);
        set_req(1, 1'b1, BASE + 4, 32'habcd0001);
        set_req(2, 1'b1, BASE + 8, 32'hdead0011);
        set_req(3, 1'b1, BASE + 12, 32'hbeef0011);
        run(4'hF, 3, 4);
        check("contention_order", {order[0][1:0], order[1][1:0], order[2][1:0], order[3][1:0]}, 8'b00_01_10_11);

        for (int i = 0; i < 4; i++) req_we[i] = 1'b0;
        run(4'hF, 3, 4);
        check("contention_rd", {got_rd[0], got_rd[1], got_rd[2], got_rd[3]},
              128'h0101FFFF_abcd0001_dead0011_beef0011);

        aw_dly = 3; w_dly = 0; b_dly = 2;
        set_req(2, 1'b1, BASE + 8, 32'h12345678);
        run(4'b0100, 8, 0);
        aw_dly = 0; b_dly = 0;
        set_req(2, 1'b0, BASE + 8, 32'h0);
        run(4'b0100, 3, 0);
        check("backpressure_rd", last_rdata, 32'h12345678);

        r_err = 2'b10;
        set_req(1, 1'b0, BASE + 4, 32'h0);
        run(4'b0010, 3, 0);
        check("slverr_resp", last_resp, 2'b10);
        check("slverr_rdata", last_rdata, 32'habcd0001);
        r_err = 2'b00;
        run(4'b0010, 3, 0);
        check("after_err_resp", last_resp, 2'b00);

        b_dly = 5;
        set_req(1, 1'b1, BASE + 16, 32'hcafe0000);
        @(posedge clk); #1;
        req = 4'b0010;
        for (int c = 0; c < 50 && !bready; c++) begin @(posedge clk); #1; end
        check("reach_b_state", bready, 1'b1);
        rst = 1'b1; req = '0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b0; b_dly = 0;
        set_req(2, 1'b0, BASE + 8, 32'h0);
        run(4'b0100, 3, 0);
        check("post_reset_rd", last_rdata, 32'h12345678);
        set_req(0, 1'b0, BASE + 4, 32'h0);
        set_req(1, 1'b0, BASE + 0, 32'h0);
        run(4'b0011, 3, 4);
        check("post_reset_order", {order[0][1:0], order[1][1:0]}, 4'b00_01);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
